neopixel_decoder: RTL and testbench

- Serial-to-parallel receiver for the single-wire WS2812 ("NeoPixel") stream that the game controller drives on neopixel_data.
- Measures high-pulse widths to recover bits, assembles 24-bit GRB pixel words MSB-first, and detects the low latch gap that ends a frame.
- Used as a loopback checker on the board and as the scoreboard front end in game-level benches: the feedback and round LEDs are read back as parallel pixel words.

---
 rtl/neopixel_decoder_pkg.sv | 29 ++
 rtl/neopixel_decoder_if.sv | 29 ++
 rtl/neopixel_decoder_pulse_width_counter.sv | 61 ++++++
 rtl/neopixel_decoder.sv | 159 +++++++++++++++
 tb/tb_neopixel_decoder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neopixel_decoder_pkg.sv
// Shared types and 50 MHz WS2812 timing constants for the NeoPixel decoder
// and the controller that drives the line.
package neopixel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        ERR  = 2'd3
    } state_t;

    // First-received byte is green, so it lands in the top bits.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    localparam int T_MIN_HIGH_50M   = 10;
    localparam int T_BIT_THRESH_50M = 30;
    localparam int T_MAX_HIGH_50M   = 60;
    localparam int T_LATCH_50M      = 2500;

    // Width counters must be able to represent both "too long high" and the latch gap.
    function automatic int cnt_sat(input int max_high, input int latch);
        return (max_high + 1 > latch) ? max_high + 1 : latch;
    endfunction

endpackage

// File: rtl/neopixel_decoder_if.sv
// Serial line plus decoded pixel/frame outputs of the NeoPixel decoder.
interface neopixel_decoder_if #(
    parameter int NUM_PIXELS = 8
);
    import neopixel_pkg::*;

    localparam int IW = $clog2(NUM_PIXELS);

    logic          neopixel_data;
    logic          pixel_valid;
    grb_t          grb;
    logic [IW-1:0] pixel_index;
    logic          frame_done;
    logic [IW:0]   pixel_count;
    logic          frame_error;

    // Side that drives the serial line and consumes decoded pixels.
    modport master (
        output neopixel_data,
        input  pixel_valid, grb, pixel_index, frame_done, pixel_count, frame_error
    );

    // The decoder itself.
    modport slave (
        input  neopixel_data,
        output pixel_valid, grb, pixel_index, frame_done, pixel_count, frame_error
    );

endinterface

// File: rtl/neopixel_decoder_pulse_width_counter.sv
// Synchronizes the raw line, flags edges and measures high/low run lengths.
// Counters count cycles of the registered level, so in the cycle an edge
// is flagged the counter of the phase that just ended still holds its width.
module pulse_width_counter #(
    parameter int CNT_MAX = 2500,
    parameter int CW      = $clog2(CNT_MAX + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_line,
    output logic          o_level,
    output logic          o_rise,
    output logic          o_fall,
    output logic [CW-1:0] o_high_cnt,
    output logic [CW-1:0] o_low_cnt
);

    localparam logic [CW-1:0] SAT = CW'(CNT_MAX);

    logic          r_sync1, r_sync2, r_level;
    logic          r_rise, r_fall;
    logic [CW-1:0] r_high_cnt, r_low_cnt;

    // Two-flop synchronizer, a level copy and registered edge flags aligned with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_level <= r_sync2;
            r_rise  <= r_sync2 & ~r_level;
            r_fall  <= ~r_sync2 & r_level;
        end
    end

    // Saturating run-length counters; each clears once the opposite level is seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_high_cnt <= '0;
            r_low_cnt  <= '0;
        end else if (r_level) begin
            r_low_cnt <= '0;
            if (r_high_cnt != SAT) r_high_cnt <= r_high_cnt + 1'b1;
        end else begin
            r_high_cnt <= '0;
            if (r_low_cnt != SAT) r_low_cnt <= r_low_cnt + 1'b1;
        end
    end

    assign o_level    = r_level;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_high_cnt = r_high_cnt;
    assign o_low_cnt  = r_low_cnt;

endmodule

// File: rtl/neopixel_decoder.sv
// WS2812 receiver: pulse-width bit recovery, 24-bit GRB assembly and
// latch-gap frame detection with per-frame error reporting.
module neopixel_decoder import neopixel_pkg::*; #(
    parameter int NUM_PIXELS   = 8,
    parameter int T_MIN_HIGH   = T_MIN_HIGH_50M,
    parameter int T_BIT_THRESH = T_BIT_THRESH_50M,
    parameter int T_MAX_HIGH   = T_MAX_HIGH_50M,
    parameter int T_LATCH      = T_LATCH_50M
) (
    input  logic                clock,
    input  logic                reset,
    neopixel_decoder_if.slave   bus
);

    localparam int IW      = $clog2(NUM_PIXELS);
    localparam int CNT_MAX = cnt_sat(T_MAX_HIGH, T_LATCH);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] C_MIN    = CW'(T_MIN_HIGH);
    localparam logic [CW-1:0] C_THRESH = CW'(T_BIT_THRESH);
    localparam logic [CW-1:0] C_MAX    = CW'(T_MAX_HIGH);
    localparam logic [CW-1:0] C_LATCH  = CW'(T_LATCH);
    localparam logic [IW:0]   C_NPIX   = (IW + 1)'(NUM_PIXELS);
    localparam logic [4:0]    C_BITS   = 5'd24;

    logic          w_level, w_rise, w_fall;
    logic [CW-1:0] w_high_cnt, w_low_cnt;
    logic          w_short, w_long, w_latch;

    state_t        r_state, w_next;
    logic          w_shift, w_bit, w_to_err, w_frame_end;

    logic [23:0]   r_shift;
    logic [4:0]    r_bit_cnt;
    logic [IW:0]   r_idx;
    logic          r_err;

    logic          r_pixel_valid, r_frame_done, r_frame_error;
    grb_t          r_grb;
    logic [IW-1:0] r_pixel_index;
    logic [IW:0]   r_pixel_count;

    pulse_width_counter #(
        .CNT_MAX (CNT_MAX),
        .CW      (CW)
    ) u_pwc (
        .clock      (clock),
        .reset      (reset),
        .i_line     (bus.neopixel_data),
        .o_level    (w_level),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_high_cnt (w_high_cnt),
        .o_low_cnt  (w_low_cnt)
    );

    assign w_short = (w_high_cnt < C_MIN);
    assign w_long  = (w_high_cnt > C_MAX);
    assign w_latch = ~w_level && (w_low_cnt >= C_LATCH);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a pulse is also illegal if it ended one cycle past the max.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_rise) w_next = HIGH;
            HIGH: begin
                if (w_fall)      w_next = (w_short || w_long) ? ERR : LOW;
                else if (w_long) w_next = ERR;
            end
            LOW: begin
                if (w_rise)       w_next = HIGH;
                else if (w_latch) w_next = IDLE;
            end
            ERR: if (w_latch) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-state strobes driving the datapath.
    always_comb begin
        w_shift     = 1'b0;
        w_bit       = 1'b0;
        w_to_err    = 1'b0;
        w_frame_end = 1'b0;
        unique case (r_state)
            HIGH: begin
                if (w_fall && !(w_short || w_long)) begin
                    w_shift = 1'b1;
                    w_bit   = (w_high_cnt >= C_THRESH);
                end else if (w_fall || w_long) begin
                    w_to_err = 1'b1;
                end
            end
            LOW:     w_frame_end = w_latch;
            ERR:     w_frame_end = w_latch;
            default: ;
        endcase
    end

    // Shift register, pixel emission, overflow/error accumulation and frame close.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_idx         <= '0;
            r_err         <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_grb         <= '0;
            r_pixel_index <= '0;
            r_frame_done  <= 1'b0;
            r_pixel_count <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            if (w_shift) begin
                r_shift   <= {r_shift[22:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_bit_cnt == C_BITS) begin
                r_bit_cnt <= '0;
                if (r_idx == C_NPIX) begin
                    r_err <= 1'b1;
                end else begin
                    r_pixel_valid <= 1'b1;
                    r_grb         <= grb_t'(r_shift);
                    r_pixel_index <= r_idx[IW-1:0];
                    r_idx         <= r_idx + 1'b1;
                end
            end
            if (w_to_err) begin
                r_err     <= 1'b1;
                r_bit_cnt <= '0;
            end
            if (w_frame_end) begin
                r_frame_done  <= 1'b1;
                r_pixel_count <= r_idx;
                r_frame_error <= r_err | (r_bit_cnt != '0);
                r_idx         <= '0;
                r_bit_cnt     <= '0;
                r_err         <= 1'b0;
            end
        end
    end

    assign bus.pixel_valid = r_pixel_valid;
    assign bus.grb         = r_grb;
    assign bus.pixel_index = r_pixel_index;
    assign bus.frame_done  = r_frame_done;
    assign bus.pixel_count = r_pixel_count;
    assign bus.frame_error = r_frame_error;

endmodule

// File: tb/tb_neopixel_decoder.sv
// Bench for neopixel_decoder: table of frames, random frames against a
// pulse-list reference model, and an asynchronous mid-frame reset.
module tb_neopixel_decoder;

    localparam int NP        = 8;
    localparam int LATCH_LOW = 2530;

    typedef struct { int hi; int lo; } pulse_t;
    typedef struct { logic [23:0] grb; int idx; } pix_t;
    typedef struct {
        string name;
        int    npix;
        int    tail;
        int    gbit;
        int    gw;
        bit    probe;
        int    epv;
        int    ecnt;
        bit    eerr;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    neopixel_decoder_if #(.NUM_PIXELS(NP)) bus ();

    neopixel_decoder #(.NUM_PIXELS(NP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    pulse_t      pq[$];
    logic [23:0] exp_px[$];
    int          exp_cnt;
    bit          exp_err;
    pix_t        obs_px[$];
    int          obs_fd_cnt[$];
    bit          obs_fd_err[$];
    vec_t        vq[$];

    // Output monitor, sampled 1 time unit after the active edge.
    always @(posedge clock) begin
        pix_t p;
        #1;
        if (bus.pixel_valid) begin
            p.grb = bus.grb;
            p.idx = int'(bus.pixel_index);
            obs_px.push_back(p);
        end
        if (bus.frame_done) begin
            obs_fd_cnt.push_back(int'(bus.pixel_count));
            obs_fd_err.push_back(bus.frame_error);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_pulse(input int hi, input int lo);
        pulse_t p;
        p.hi = hi;
        p.lo = lo;
        pq.push_back(p);
    endtask

    task automatic add_bit(input bit b);
        if (b) add_pulse(40, 22);
        else   add_pulse(20, 42);
    endtask

    task automatic add_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) add_bit(w[i]);
    endtask

    task automatic set_hi(input int k, input int hi);
        pulse_t p;
        p = pq[k];
        p.hi = hi;
        pq[k] = p;
    endtask

    // Reference: legal pulses become bits, every 24 form a pixel, the first illegal
    // pulse poisons the rest of the frame, leftover bits at the latch are an error.
    task automatic model();
        bit          dead;
        int          nb;
        logic [23:0] w;
        dead = 0;
        nb   = 0;
        w    = '0;
        exp_px.delete();
        exp_err = 0;
        foreach (pq[k]) begin
            if (!dead) begin
                if (pq[k].hi < 10 || pq[k].hi > 60) begin
                    exp_err = 1;
                    dead    = 1;
                    nb      = 0;
                end else begin
                    w = {w[22:0], (pq[k].hi >= 30)};
                    nb++;
                    if (nb == 24) begin
                        nb = 0;
                        if (exp_px.size() < NP) exp_px.push_back(w);
                        else                    exp_err = 1;
                    end
                end
            end
        end
        if (nb != 0) exp_err = 1;
        exp_cnt = exp_px.size();
    endtask

    task automatic drive_pulses(input bit latch);
        pulse_t t;
        if (latch && pq.size() > 0) begin
            t = pq[pq.size()-1];
            t.lo = LATCH_LOW;
            pq[pq.size()-1] = t;
        end
        foreach (pq[k]) begin
            @(negedge clock);
            bus.neopixel_data = 1'b1;
            repeat (pq[k].hi) @(negedge clock);
            bus.neopixel_data = 1'b0;
            repeat (pq[k].lo - 1) @(negedge clock);
        end
    endtask

    task automatic clear_obs();
        obs_px.delete();
        obs_fd_cnt.delete();
        obs_fd_err.delete();
    endtask

    task automatic run_frame(input string name, input int epv, input int ecnt, input bit eerr);
        model();
        clear_obs();
        drive_pulses(1);
        for (int c = 0; c < 200 && obs_fd_cnt.size() == 0; c++) @(negedge clock);
        repeat (4) @(negedge clock);
        check({name, ".pv_count"}, obs_px.size(), epv);
        for (int i = 0; i < obs_px.size() && i < exp_px.size(); i++) begin
            check($sformatf("%s.grb[%0d]", name, i), obs_px[i].grb, exp_px[i]);
            check($sformatf("%s.index[%0d]", name, i), obs_px[i].idx, i);
        end
        check({name, ".frame_done_count"}, obs_fd_cnt.size(), 1);
        if (obs_fd_cnt.size() > 0) begin
            check({name, ".pixel_count"}, obs_fd_cnt[0], ecnt);
            check({name, ".frame_error"}, obs_fd_err[0], eerr);
        end
    endtask

    task automatic add_vec(input string nm, input int np, input int tl, input int gb,
                           input int gw, input bit pr, input int epv, input int ecnt,
                           input bit eerr);
        vec_t v;
        v.name = nm; v.npix = np; v.tail = tl; v.gbit = gb; v.gw = gw;
        v.probe = pr; v.epv = epv; v.ecnt = ecnt; v.eerr = eerr;
        vq.push_back(v);
    endtask

    task automatic build(input vec_t v);
        logic [23:0] w;
        pulse_t      g;
        pq.delete();
        for (int i = 0; i < v.npix; i++) begin
            w = (v.npix == 1) ? 24'h00FF00 : 24'(24'h010203 * i);
            add_word(w);
        end
        for (int i = 0; i < v.tail; i++) add_bit(i[0]);
        if (v.probe) begin
            set_hi(20, 10);
            set_hi(21, 29);
            set_hi(22, 30);
            set_hi(23, 60);
        end
        if (v.gbit >= 0) begin
            g.hi = v.gw;
            g.lo = 42;
            pq.insert(v.gbit, g);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [23:0] g;
        g = bus.grb;
        check({name, ".pixel_valid"}, bus.pixel_valid, 0);
        check({name, ".grb"}, g, 0);
        check({name, ".pixel_index"}, bus.pixel_index, 0);
        check({name, ".frame_done"}, bus.frame_done, 0);
        check({name, ".pixel_count"}, bus.pixel_count, 0);
        check({name, ".frame_error"}, bus.frame_error, 0);
    endtask

    initial begin
        logic [23:0] g;
        int          nb, r, hi;

        //        name           npix tail gbit gw  probe pv cnt err
        add_vec("one_pixel",    1,   0,   -1,  0,  0,    1, 1,  0);
        add_vec("eight_pixels", 8,   0,   -1,  0,  0,    8, 8,  0);
        add_vec("nine_pixels",  9,   0,   -1,  0,  0,    8, 8,  1);
        add_vec("glitch_mid",   1,   0,   10,  5,  0,    0, 0,  1);
        add_vec("clean_after",  1,   0,   -1,  0,  0,    1, 1,  0);
        add_vec("partial_12",   0,   12,  -1,  0,  0,    0, 0,  1);
        add_vec("bit_bounds",   1,   0,   -1,  0,  1,    1, 1,  0);
        add_vec("short_9",      0,   0,   0,   9,  0,    0, 0,  1);
        add_vec("long_61",      0,   0,   0,   61, 0,    0, 0,  1);

        bus.neopixel_data = 1'b0;
        repeat (4) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clock);

        foreach (vq[k]) begin
            build(vq[k]);
            run_frame(vq[k].name, vq[k].epv, vq[k].ecnt, vq[k].eerr);
        end

        // Random frames: mostly legal widths, occasional short or long pulses.
        for (int f = 0; f < 4; f++) begin
            pq.delete();
            nb = ($urandom_range(0, 2) == 0) ? 24 * $urandom_range(1, 2) : $urandom_range(1, 50);
            for (int i = 0; i < nb; i++) begin
                r = $urandom_range(0, 99);
                if (r < 1)      hi = $urandom_range(1, 9);
                else if (r < 2) hi = $urandom_range(61, 75);
                else            hi = $urandom_range(10, 60);
                add_pulse(hi, $urandom_range(3, 30));
            end
            model();
            run_frame($sformatf("rand%0d", f), exp_px.size(), exp_cnt, exp_err);
        end

        // Asynchronous reset in the middle of pixel 3.
        pq.delete();
        for (int i = 0; i < 3; i++) add_word(24'(24'h010203 * (i + 1)));
        for (int i = 0; i < 10; i++) add_bit(i[0]);
        clear_obs();
        drive_pulses(0);
        @(negedge clock);
        bus.neopixel_data = 1'b1;
        repeat (5) @(negedge clock);
        check("rst.pre_pv_count", obs_px.size(), 3);
        g = bus.grb;
        check("rst.pre_grb", g, 24'h030609);
        #3;
        reset = 1'b1;
        #1;
        check_outputs_zero("rst.async");
        bus.neopixel_data = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        pq.delete();
        add_word(24'hA5C30F);
        run_frame("post_reset", 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
